candy_regfile_mp: RTL and testbench

- Parametrised multi-port general-purpose register file. Successor to the fixed 2-read/1-write candy_regs.
- Adds configurable width, depth and port counts, and deterministic multi-write collision resolution.
- Adds an optional registered-read mode and a per-register pending-write scoreboard for the decode stage's hazard detection.
- Sits between decode (read ports, scoreboard set) and writeback (write ports, scoreboard clear).

---
 rtl/candy_regfile_mp_if.sv | 29 ++
 rtl/candy_regfile_mp.sv | 134 +++++++++++++
 tb/tb_candy_regfile_mp.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/candy_regfile_mp_if.sv
// Bundle of the register-file ports: write ports, read ports and scoreboard controls.
// Multi-port fields are packed with port i at [i*W +: W].
interface candy_regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2,
   parameter int NWR    = 1
);
   logic [NWR-1:0]        we;
   logic [NWR*ADDR_W-1:0] waddr;
   logic [NWR*DATA_W-1:0] wdata;
   logic [NRD-1:0]        re;
   logic [NRD*ADDR_W-1:0] raddr;
   logic [NRD*DATA_W-1:0] rdata;
   logic [NRD-1:0]        rbusy;
   logic                  sb_set;
   logic [ADDR_W-1:0]     sb_addr;
   logic                  sb_flush;

   modport master (
      output we, waddr, wdata, re, raddr, sb_set, sb_addr, sb_flush,
      input  rdata, rbusy
   );

   modport slave (
      input  we, waddr, wdata, re, raddr, sb_set, sb_addr, sb_flush,
      output rdata, rbusy
   );
endinterface

// File: rtl/candy_regfile_mp.sv
// Multi-port register file with same-cycle write bypass and a pending-write scoreboard.
// Read latency 0 (READ_REG=0) or 1 (READ_REG=1); always accepts, never applies backpressure.
module candy_regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int READ_REG = 0,
   parameter int ZERO_R0  = 1
) (
   input  logic               clk,
   input  logic               rst,
   candy_regfile_mp_if.slave  bus
);

   logic [DATA_W-1:0]     r_regs [DEPTH];
   logic [DEPTH-1:0]      r_busy;

   logic [ADDR_W-1:0]     w_waddr [NWR];
   logic [DATA_W-1:0]     w_wdata [NWR];
   logic [ADDR_W-1:0]     w_raddr [NRD];
   logic [NWR-1:0]        w_wr_win;
   logic [DEPTH-1:0]      w_wr_hit;
   logic [DEPTH-1:0]      w_busy_nxt;
   logic                  w_sb_ok;
   logic [DATA_W-1:0]     w_rd_val [NRD];
   logic [NRD-1:0]        w_rd_busy;
   logic [NRD*DATA_W-1:0] w_rdata_pk;

   for (genvar j = 0; j < NWR; j++) begin : g_wunpack
      assign w_waddr[j] = bus.waddr[j*ADDR_W +: ADDR_W];
      assign w_wdata[j] = bus.wdata[j*DATA_W +: DATA_W];
   end

   for (genvar i = 0; i < NRD; i++) begin : g_runpack
      assign w_raddr[i] = bus.raddr[i*ADDR_W +: ADDR_W];
      assign w_rdata_pk[i*DATA_W +: DATA_W] = w_rd_val[i];
   end

   // A write survives only if no higher-numbered port targets the same register.
   always_comb begin
      w_wr_win = '0;
      for (int j = 0; j < NWR; j++) begin
         w_wr_win[j] = bus.we[j] && !((ZERO_R0 != 0) && (w_waddr[j] == '0));
         for (int k = j + 1; k < NWR; k++) begin
            if (bus.we[k] && (w_waddr[k] == w_waddr[j])) begin
               w_wr_win[j] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < DEPTH; a++) begin
            r_regs[a] <= '0;
         end
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (w_wr_win[j]) begin
               r_regs[w_waddr[j]] <= w_wdata[j];
            end
         end
      end
   end

   always_comb begin
      w_wr_hit = '0;
      for (int j = 0; j < NWR; j++) begin
         if (bus.we[j]) begin
            w_wr_hit[w_waddr[j]] = 1'b1;
         end
      end
   end

   assign w_sb_ok = bus.sb_set && !((ZERO_R0 != 0) && (bus.sb_addr == '0));

   // Allocation applied after retirement so a new destination stays pending.
   always_comb begin
      w_busy_nxt = r_busy & ~w_wr_hit;
      if (w_sb_ok) begin
         w_busy_nxt[bus.sb_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= '0;
      end else if (bus.sb_flush) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         w_rd_val[i]  = '0;
         w_rd_busy[i] = bus.re[i] & r_busy[w_raddr[i]];
         if (bus.re[i] && !((ZERO_R0 != 0) && (w_raddr[i] == '0))) begin
            w_rd_val[i] = r_regs[w_raddr[i]];
            // Ascending scan leaves the highest-numbered matching port, matching the write winner.
            for (int j = 0; j < NWR; j++) begin
               if (bus.we[j] && (w_waddr[j] == w_raddr[i])) begin
                  w_rd_val[i] = w_wdata[j];
               end
            end
         end
      end
   end

   if (READ_REG != 0) begin : g_rreg
      logic [NRD*DATA_W-1:0] r_rdata;
      logic [NRD-1:0]        r_rbusy;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_rdata <= '0;
            r_rbusy <= '0;
         end else begin
            r_rdata <= w_rdata_pk;
            r_rbusy <= w_rd_busy;
         end
      end

      assign bus.rdata = r_rdata;
      assign bus.rbusy = r_rbusy;
   end else begin : g_rcomb
      assign bus.rdata = rst ? '0 : w_rdata_pk;
      assign bus.rbusy = rst ? '0 : w_rd_busy;
   end

endmodule

// File: tb/tb_candy_regfile_mp.sv
// Drives one combinational-read and one registered-read instance with identical stimulus;
// expected results are queued per step and compared when each instance presents them.
module tb_candy_regfile_mp;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NW = 2;

   typedef struct packed {
      logic [DW-1:0] d1;
      logic [DW-1:0] d0;
      logic          b1;
      logic          b0;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [NW-1:0] we;
   logic [AW-1:0] wa0, wa1;
   logic [DW-1:0] wd0, wd1;
   logic [NR-1:0] re;
   logic [AW-1:0] ra0, ra1;
   logic          sb_set;
   logic [AW-1:0] sb_addr;
   logic          sb_flush;

   exp_t  q_c[$];
   exp_t  q_r[$];
   string q_ct[$];
   string q_rt[$];
   int    n_pass  = 0;
   int    n_total = 0;

   always #5 clk = ~clk;

   candy_regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) if_c ();
   candy_regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) if_r ();

   assign if_c.we       = we;
   assign if_c.waddr    = {wa1, wa0};
   assign if_c.wdata    = {wd1, wd0};
   assign if_c.re       = re;
   assign if_c.raddr    = {ra1, ra0};
   assign if_c.sb_set   = sb_set;
   assign if_c.sb_addr  = sb_addr;
   assign if_c.sb_flush = sb_flush;
   assign if_r.we       = we;
   assign if_r.waddr    = {wa1, wa0};
   assign if_r.wdata    = {wd1, wd0};
   assign if_r.re       = re;
   assign if_r.raddr    = {ra1, ra0};
   assign if_r.sb_set   = sb_set;
   assign if_r.sb_addr  = sb_addr;
   assign if_r.sb_flush = sb_flush;

   candy_regfile_mp #(
      .DATA_W(DW), .DEPTH(32), .ADDR_W(AW), .NRD(NR), .NWR(NW), .READ_REG(0), .ZERO_R0(1)
   ) u_comb (
      .clk(clk), .rst(rst), .bus(if_c)
   );

   candy_regfile_mp #(
      .DATA_W(DW), .DEPTH(32), .ADDR_W(AW), .NRD(NR), .NWR(NW), .READ_REG(1), .ZERO_R0(1)
   ) u_reg (
      .clk(clk), .rst(rst), .bus(if_r)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic idle();
      rst = 1'b0; we = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
      re = '0; ra0 = '0; ra1 = '0; sb_set = 1'b0; sb_addr = '0; sb_flush = 1'b0;
   endtask

   // Inputs are already driven; queue the expectation, check both instances, advance a cycle.
   task automatic step(input string tag, input logic [DW-1:0] d0, input logic b0,
                       input logic [DW-1:0] d1, input logic b1);
      exp_t  e;
      string t;
      e = '{d1: d1, d0: d0, b1: b1, b0: b0};
      q_c.push_back(e); q_ct.push_back(tag);
      q_r.push_back(e); q_rt.push_back(tag);
      @(negedge clk);
      if (q_r.size() > 1) begin
         e = q_r.pop_front(); t = {"reg_", q_rt.pop_front()};
         chk({t, "_d0"}, if_r.rdata[DW-1:0], e.d0);
         chk({t, "_d1"}, if_r.rdata[2*DW-1:DW], e.d1);
         chk({t, "_b0"}, {31'd0, if_r.rbusy[0]}, {31'd0, e.b0});
         chk({t, "_b1"}, {31'd0, if_r.rbusy[1]}, {31'd0, e.b1});
      end
      e = q_c.pop_front(); t = {"comb_", q_ct.pop_front()};
      chk({t, "_d0"}, if_c.rdata[DW-1:0], e.d0);
      chk({t, "_d1"}, if_c.rdata[2*DW-1:DW], e.d1);
      chk({t, "_b0"}, {31'd0, if_c.rbusy[0]}, {31'd0, e.b0});
      chk({t, "_b1"}, {31'd0, if_c.rbusy[1]}, {31'd0, e.b1});
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle(); rst = 1'b1; re = 2'b11;
      step("reset", 0, 0, 0, 0);

      for (int a = 0; a < 32; a++) begin
         idle(); re = 2'b11; ra0 = AW'(a); ra1 = AW'(31 - a);
         step("rst_rd", 0, 0, 0, 0);
      end

      idle(); we = 2'b01; wa0 = 5'd0; wd0 = 32'hDEADBEEF; re = 2'b01; ra0 = 5'd0;
      step("r0_wr", 0, 0, 0, 0);
      idle(); re = 2'b11; ra0 = 5'd0; ra1 = 5'd0;
      step("r0_rd", 0, 0, 0, 0);

      idle(); we = 2'b01; wa0 = 5'd5; wd0 = 32'h12345678; re = 2'b11; ra0 = 5'd5; ra1 = 5'd5;
      step("r5_byp", 32'h12345678, 0, 32'h12345678, 0);
      idle(); re = 2'b10; ra0 = 5'd5; ra1 = 5'd5;
      step("r5_rd", 0, 0, 32'h12345678, 0);

      idle(); we = 2'b11; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'hAAAA0000; wd1 = 32'h0000BBBB;
      re = 2'b11; ra0 = 5'd7; ra1 = 5'd7;
      step("coll_byp", 32'h0000BBBB, 0, 32'h0000BBBB, 0);
      idle(); re = 2'b11; ra0 = 5'd7; ra1 = 5'd7;
      step("coll_rd", 32'h0000BBBB, 0, 32'h0000BBBB, 0);

      idle(); we = 2'b11; wa0 = 5'd20; wa1 = 5'd21; wd0 = 32'h2020; wd1 = 32'h2121;
      step("dual_wr", 0, 0, 0, 0);
      idle(); re = 2'b11; ra0 = 5'd20; ra1 = 5'd21;
      step("dual_rd", 32'h2020, 0, 32'h2121, 0);

      idle(); we = 2'b01; wa0 = 5'd3; wd0 = 32'h55;
      step("r3_wr", 0, 0, 0, 0);
      idle(); re = 2'b01; ra0 = 5'd3; ra1 = 5'd3;
      step("r3_rd", 32'h55, 0, 0, 0);

      idle(); sb_set = 1'b1; sb_addr = 5'd9; re = 2'b01; ra0 = 5'd9;
      step("sb9_set", 0, 0, 0, 0);
      idle(); re = 2'b01; ra0 = 5'd9; ra1 = 5'd9;
      step("sb9_busy", 0, 1, 0, 0);
      idle(); we = 2'b01; wa0 = 5'd9; wd0 = 32'h99; sb_set = 1'b1; sb_addr = 5'd9;
      re = 2'b11; ra0 = 5'd9; ra1 = 5'd9;
      step("sb9_setclr", 32'h99, 1, 32'h99, 1);
      idle(); re = 2'b11; ra0 = 5'd9; ra1 = 5'd9;
      step("sb9_setwin", 32'h99, 1, 32'h99, 1);
      idle(); we = 2'b01; wa0 = 5'd9; wd0 = 32'h9A; re = 2'b11; ra0 = 5'd9; ra1 = 5'd9;
      step("sb9_clr", 32'h9A, 1, 32'h9A, 1);
      idle(); re = 2'b11; ra0 = 5'd9; ra1 = 5'd9;
      step("sb9_free", 32'h9A, 0, 32'h9A, 0);

      idle(); sb_set = 1'b1; sb_addr = 5'd4; re = 2'b01; ra0 = 5'd4;
      step("sb4_set", 0, 0, 0, 0);
      idle(); sb_flush = 1'b1; re = 2'b01; ra0 = 5'd4;
      step("sb4_flush", 0, 1, 0, 0);
      idle(); re = 2'b01; ra0 = 5'd4;
      step("sb4_flushed", 0, 0, 0, 0);
      idle(); sb_set = 1'b1; sb_addr = 5'd4; sb_flush = 1'b1; re = 2'b01; ra0 = 5'd4;
      step("sb4_flushset", 0, 0, 0, 0);
      idle(); re = 2'b01; ra0 = 5'd4;
      step("sb4_flushwin", 0, 0, 0, 0);

      idle(); sb_set = 1'b1; sb_addr = 5'd0;
      step("sb0_set", 0, 0, 0, 0);
      idle(); re = 2'b11; ra0 = 5'd0; ra1 = 5'd0;
      step("sb0_never", 0, 0, 0, 0);

      idle(); sb_set = 1'b1; sb_addr = 5'd10;
      step("sb10_set", 0, 0, 0, 0);
      idle(); sb_set = 1'b1; sb_addr = 5'd11; re = 2'b01; ra0 = 5'd10;
      step("sb11_set", 0, 1, 0, 0);
      idle(); re = 2'b11; ra0 = 5'd10; ra1 = 5'd11;
      step("pre_rst", 0, 1, 0, 1);

      idle(); rst = 1'b1; we = 2'b01; wa0 = 5'd10; wd0 = 32'hFF; sb_set = 1'b1; sb_addr = 5'd12;
      re = 2'b11; ra0 = 5'd10; ra1 = 5'd11;
      step("mid_rst", 0, 0, 0, 0);
      idle(); re = 2'b11; ra0 = 5'd10; ra1 = 5'd11;
      step("post_rst", 0, 0, 0, 0);
      idle(); re = 2'b11; ra0 = 5'd12; ra1 = 5'd5;
      step("post_rst2", 0, 0, 0, 0);

      idle();
      step("drain", 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
